// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared items for the 11010 sync-pattern link (tx and detector)
package pattern_pkg;

    localparam int                       PATTERN_W_DEF = 5;
    localparam logic [PATTERN_W_DEF-1:0] PATTERN_DEF   = 5'b11010;

    localparam logic B = 1'b1;
    localparam logic C = 1'b0;

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_SYNC = 5'b00010;
    localparam logic [4:0] S_DATA = 5'b00100;
    localparam logic [4:0] S_PAR  = 5'b01000;
    localparam logic [4:0] S_GAP  = 5'b10000;

    typedef enum logic [4:0] {
        ST_IDLE = S_IDLE,
        ST_SYNC = S_SYNC,
        ST_DATA = S_DATA,
        ST_PAR  = S_PAR,
        ST_GAP  = S_GAP
    } state_t;

endpackage

// File: rtl/pattern_piso.sv
// rtl/pattern_piso.sv - parallel-load, shift-on-enable MSB-first shift register
module pattern_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         shift_i,
    output logic         msb_o
);

    logic [W-1:0] sr_q;

    // Load wins over shift; shifting fills zeros from the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= load_data_i;
        end else if (shift_i) begin
            sr_q <= sr_q << 1;
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/pattern_frame_tx.sv
// rtl/pattern_frame_tx.sv - sync word + payload serial frame transmitter (option: PATTERN_TX_PARITY_EN)
module pattern_frame_tx
    import pattern_pkg::*;
#(
    parameter int                   PATTERN_W = PATTERN_W_DEF,
    parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_DEF,
    parameter int                   PAYLOAD_W = 8,
    parameter int                   GAP       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic                 ready_i,
    output logic                 data_o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CNT_MAX = (PATTERN_W > PAYLOAD_W) ? PATTERN_W : PAYLOAD_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CNT_W-1:0]     SYNC_LAST = CNT_W'(PATTERN_W - 1);
    localparam logic [CNT_W-1:0]     DATA_LAST = CNT_W'(PAYLOAD_W - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST  = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
    // The first sync bit goes straight to data_o on accept, so the sync
    // register only needs to hold the remaining bits.
    localparam logic [PATTERN_W-1:0] SYNC_REST = PATTERN << 1;

    state_t           state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             data_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
`ifdef PATTERN_TX_PARITY_EN
    logic             par_q;
`endif

    logic xfer;
    logic accept;
    logic sync_last;
    logic data_last;
    logic frame_end;
    logic sync_msb;
    logic pay_msb;
    logic sync_shift;
    logic pay_shift;

    assign xfer      = valid_q && ready_i;
    assign accept    = (state_q == ST_IDLE) && start_i;
    assign sync_last = (bit_cnt_q == SYNC_LAST);
    assign data_last = (bit_cnt_q == DATA_LAST);
`ifdef PATTERN_TX_PARITY_EN
    assign frame_end = xfer && (state_q == ST_PAR);
`else
    assign frame_end = xfer && (state_q == ST_DATA) && data_last;
`endif

    // Each register advances exactly when its current head bit has been handed to data_o.
    assign sync_shift = xfer && (state_q == ST_SYNC) && !sync_last;
    assign pay_shift  = xfer && (((state_q == ST_SYNC) && sync_last) ||
                                 ((state_q == ST_DATA) && !data_last));

    pattern_piso #(.W(PATTERN_W)) u_sync_sr (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .load_data_i (SYNC_REST),
        .shift_i     (sync_shift),
        .msb_o       (sync_msb)
    );

    pattern_piso #(.W(PAYLOAD_W)) u_pay_sr (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .load_data_i (payload_i),
        .shift_i     (pay_shift),
        .msb_o       (pay_msb)
    );

    // Frame FSM with registered outputs; data_o always carries the bit awaiting transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            data_q    <= C;
            valid_q   <= C;
            busy_q    <= C;
            done_q    <= C;
`ifdef PATTERN_TX_PARITY_EN
            par_q     <= C;
`endif
        end else begin
            done_q <= frame_end;
            if (frame_end) begin
                data_q    <= C;
                valid_q   <= C;
                bit_cnt_q <= '0;
                gap_cnt_q <= '0;
                if (GAP == 0) begin
                    state_q <= ST_IDLE;
                    busy_q  <= C;
                end else begin
                    state_q <= ST_GAP;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            state_q   <= ST_SYNC;
                            bit_cnt_q <= '0;
                            data_q    <= PATTERN[PATTERN_W-1];
                            valid_q   <= B;
                            busy_q    <= B;
`ifdef PATTERN_TX_PARITY_EN
                            par_q     <= ^payload_i;
`endif
                        end
                    end
                    ST_SYNC: begin
                        if (xfer) begin
                            if (sync_last) begin
                                state_q   <= ST_DATA;
                                bit_cnt_q <= '0;
                                data_q    <= pay_msb;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                                data_q    <= sync_msb;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (xfer) begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            data_q    <= pay_msb;
`ifdef PATTERN_TX_PARITY_EN
                            if (data_last) begin
                                state_q   <= ST_PAR;
                                bit_cnt_q <= '0;
                                data_q    <= par_q;
                            end
`endif
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_q == GAP_LAST) begin
                            state_q   <= ST_IDLE;
                            busy_q    <= C;
                            gap_cnt_q <= '0;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        valid_q <= C;
                        busy_q  <= C;
                        data_q  <= C;
                    end
                endcase
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
